pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the enable inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers (dff_stall-based). It also drives the bubble/flush controls, based on memory handshakes, load-use hazards, branch mispredicts and halt. It is the only block allowed to deassert pipeline-register enables.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
dmem_req  input  1  MEM stage performs a data-memory access this cycle
dmem_done  input  1  data memory completes access this cycle
imem_req  input  1  fetch request active this cycle
imem_done  input  1  instruction memory returns data this cycle
load_use  input  1  hazard unit: ID instruction depends on a load in EX
mispredict  input  1  EX resolved a taken/mispredicted branch; PC redirect valid this cycle
halt_req  input  1  halt instruction reached WB
en_pc  output  1  PC register enable
en_ifid  output  1  IF/ID enable
en_idex  output  1  ID/EX enable
en_exmem  output  1  EX/MEM enable
en_memwb  output  1  MEM/WB enable
bubble_idex  output  1  load NOP into ID/EX instead of decoded instruction
flush_ifid  output  1  load NOP into IF/ID
halted  output  1  core halted
stall_count  output  CNT_W  cycles with en_pc=0, excluding HALT

Behaviour:
- State register is 2 bits: RUN=00, DWAIT=01, IWAIT=10, HALT=11. It also holds the redirect_pending flag and stall_count.
- Reset (async, rst=1): state=RUN, redirect_pending=0, stall_count=0. While rst=1, all en_* = 0, bubble_idex = 0, flush_ifid = 0 and halted = 0.
- Outputs are combinational from state plus current inputs (Mealy), so a stall takes effect in the same cycle the condition appears.
- dstall = dmem_req & ~dmem_done; istall = imem_req & ~imem_done.
- Priority, highest first: HALT > dstall/DWAIT > istall/IWAIT > mispredict > load_use.
- Freeze condition: state = HALT, state = DWAIT, or (state = RUN or IWAIT) with dstall. Under freeze, all five enables = 0, bubble = 0 and flush = 0.
- Fetch-stall condition: in IWAIT, or in RUN with istall, and not frozen. Outputs: en_pc = 0, en_ifid = 0, bubble_idex = 1, en_idex = en_exmem = en_memwb = 1, flush = 0. A mispredict arriving here sets redirect_pending = 1.
- RUN, not frozen, not fetch-stalled:
  - With mispredict | redirect_pending: en_pc = 1, flush_ifid = 1, bubble_idex = 1, all enables = 1. This also clears redirect_pending and overrides load_use.
  - Else with load_use: en_pc = 0, en_ifid = 0, bubble_idex = 1, later enables = 1.
  - Else: all enables = 1, no bubble, no flush.
- Transitions:
  - RUN → HALT when halt_req and not dstall; otherwise RUN → DWAIT on dstall, else RUN → IWAIT on istall.
  - DWAIT → RUN on dmem_done.
  - IWAIT → DWAIT on dstall; IWAIT → RUN on imem_done with no dstall.
  - HALT is left only by reset. halted = 1 in HALT.
- redirect_pending is cleared only when applied in RUN. A pending redirect is applied on the first unfrozen RUN cycle after IWAIT/DWAIT exits.
- stall_count increments on every cycle with en_pc = 0 and state ≠ HALT, outside reset. It saturates at 2^CNT_W − 1 with no wrap.
- Simultaneous dmem_done and imem_req & ~imem_done in DWAIT: go to RUN. The fetch stall is then re-evaluated in RUN on the next cycle.

Test Plan:
- Reset then idle inputs: all enables 1, bubble 0, flush 0, stall_count 0, halted 0. Assert rst mid-DWAIT → all outputs 0 immediately, state RUN after release.
- dmem_req=1 with dmem_done low for 3 cycles, then high: all enables 0 for 3 cycles and the done cycle stays in DWAIT. Enables 1 the next cycle; stall_count = 4.
- load_use for 1 cycle: en_pc = en_ifid = 0, bubble_idex = 1, en_idex = 1; stall_count += 1. load_use together with mispredict: flush = 1, bubble = 1, en_pc = 1, no stall.
- istall 2 cycles with mispredict pulsed in the first: bubble = 1 for both cycles, redirect_pending set. On imem_done exit → RUN, and the next cycle gives flush_ifid = 1 and en_pc = 1.
- dstall during IWAIT: immediate full freeze, DWAIT. On dmem_done → RUN, then IWAIT if imem still pending.
- halt_req: next cycle halted = 1 and all enables 0 indefinitely, stall_count frozen. With CNT_W = 4 and 20 load_use cycles, stall_count saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: drives register
// enables, ID/EX bubble and IF/ID flush from memory handshakes and hazards.
module pipe_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmem_req,
  input  logic             dmem_done,
  input  logic             imem_req,
  input  logic             imem_done,
  input  logic             load_use,
  input  logic             mispredict,
  input  logic             halt_req,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    IWAIT = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               redirect_pending_q, redirect_pending_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic dstall, istall, frozen, fetch_stall;
  logic en_pc_c, en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
  logic bubble_c, flush_c;

  assign dstall = dmem_req & ~dmem_done;
  assign istall = imem_req & ~imem_done;

  assign frozen = (state_q == HALT) || (state_q == DWAIT) ||
                  (((state_q == RUN) || (state_q == IWAIT)) && dstall);
  assign fetch_stall = !frozen &&
                       ((state_q == IWAIT) || ((state_q == RUN) && istall));

  // Mealy enables: a stall takes effect in the cycle its condition appears.
  always_comb begin
    en_pc_c            = 1'b1;
    en_ifid_c          = 1'b1;
    en_idex_c          = 1'b1;
    en_exmem_c         = 1'b1;
    en_memwb_c         = 1'b1;
    bubble_c           = 1'b0;
    flush_c            = 1'b0;
    redirect_pending_d = redirect_pending_q;
    if (frozen) begin
      en_pc_c    = 1'b0;
      en_ifid_c  = 1'b0;
      en_idex_c  = 1'b0;
      en_exmem_c = 1'b0;
      en_memwb_c = 1'b0;
    end else if (fetch_stall) begin
      en_pc_c   = 1'b0;
      en_ifid_c = 1'b0;
      bubble_c  = 1'b1;
      if (mispredict) redirect_pending_d = 1'b1;
    end else if (mispredict || redirect_pending_q) begin
      flush_c            = 1'b1;
      bubble_c           = 1'b1;
      redirect_pending_d = 1'b0;
    end else if (load_use) begin
      en_pc_c   = 1'b0;
      en_ifid_c = 1'b0;
      bubble_c  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_req && !dstall) state_d = HALT;
        else if (dstall)         state_d = DWAIT;
        else if (istall)         state_d = IWAIT;
      end
      DWAIT: if (dmem_done) state_d = RUN;
      IWAIT: begin
        if (dstall)         state_d = DWAIT;
        else if (imem_done) state_d = RUN;
      end
      default: state_d = HALT;
    endcase
  end

  // Saturating count of PC-stalled cycles; a halted core is not stalling.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!en_pc_c && (state_q != HALT) && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= RUN;
      redirect_pending_q <= 1'b0;
      stall_count_q      <= '0;
    end else begin
      state_q            <= state_d;
      redirect_pending_q <= redirect_pending_d;
      stall_count_q      <= stall_count_d;
    end
  end

  assign en_pc       = en_pc_c & ~rst;
  assign en_ifid     = en_ifid_c & ~rst;
  assign en_idex     = en_idex_c & ~rst;
  assign en_exmem    = en_exmem_c & ~rst;
  assign en_memwb    = en_memwb_c & ~rst;
  assign bubble_idex = bubble_c & ~rst;
  assign flush_ifid  = flush_c & ~rst;
  assign halted      = (state_q == HALT) & ~rst;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, corner sequences, and
// randomized stimulus against a behavioural model (16-bit and 4-bit counters).
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic dmem_req, dmem_done, imem_req, imem_done, load_use, mispredict, halt_req;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb, bubble_idex, flush_ifid, halted;
  logic [15:0] stall_count;
  logic s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb, s_bubble, s_flush, s_halted;
  logic [3:0]  s_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .dmem_req(dmem_req), .dmem_done(dmem_done),
    .imem_req(imem_req), .imem_done(imem_done),
    .load_use(load_use), .mispredict(mispredict), .halt_req(halt_req),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .halted(halted), .stall_count(stall_count)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .dmem_req(dmem_req), .dmem_done(dmem_done),
    .imem_req(imem_req), .imem_done(imem_done),
    .load_use(load_use), .mispredict(mispredict), .halt_req(halt_req),
    .en_pc(s_en_pc), .en_ifid(s_en_ifid), .en_idex(s_en_idex),
    .en_exmem(s_en_exmem), .en_memwb(s_en_memwb),
    .bubble_idex(s_bubble), .flush_ifid(s_flush),
    .halted(s_halted), .stall_count(s_count)
  );

  // in  = {dmem_req, dmem_done, imem_req, imem_done, load_use, mispredict, halt_req}
  // ex  = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, bubble_idex, flush_ifid, halted}
  typedef struct packed {
    logic [6:0]  in;
    logic [7:0]  ex;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [0:21];

  task automatic set_in(input logic [6:0] v);
    {dmem_req, dmem_done, imem_req, imem_done, load_use, mispredict, halt_req} = v;
  endtask

  task automatic check(input string name, input logic [7:0] ex, input int cnt);
    logic [7:0] act;
    logic [7:0] act4;
    int cnt4;
    act  = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, bubble_idex, flush_ifid, halted};
    act4 = {s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb, s_bubble, s_flush, s_halted};
    cnt4 = (cnt > 15) ? 15 : cnt;
    total++;
    if (act !== ex || act4 !== ex || int'(stall_count) != cnt || int'(s_count) != cnt4) begin
      bad++;
      $display("FAIL %s t=%0t outs=%b outs4=%b count=%0d count4=%0d required outs=%b count=%0d count4=%0d",
               name, $time, act, act4, stall_count, s_count, ex, cnt, cnt4);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(7'b0);
    @(posedge clk); #1;
    check("reset_hold", 8'h00, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Behavioural model state
  bit m_dw, m_iw, m_halt, m_rp;
  int m_cnt, m_cnt4;

  function automatic logic [7:0] model_out(input logic [6:0] v, output bit fstall, output bit redir);
    bit dreq, ddone, ireq, idone, lu, mp, hr, ds, is;
    {dreq, ddone, ireq, idone, lu, mp, hr} = v;
    ds = dreq && !ddone;
    is = ireq && !idone;
    fstall = 0;
    redir  = 0;
    if (m_halt)                 return 8'b00000001;
    if (m_dw || ds)             return 8'b00000000;
    if (m_iw || is) begin fstall = 1; return 8'b00111100; end
    if (mp || m_rp) begin redir = 1;  return 8'b11111110; end
    if (lu)                     return 8'b00111100;
    return 8'b11111000;
  endfunction

  task automatic model_step(input logic [6:0] v, input logic [7:0] ex, input bit fstall, input bit redir);
    bit dreq, ddone, ireq, idone, lu, mp, hr, ds, is;
    {dreq, ddone, ireq, idone, lu, mp, hr} = v;
    ds = dreq && !ddone;
    is = ireq && !idone;
    if (!ex[7] && !m_halt) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (fstall && mp) m_rp = 1;
    if (redir) m_rp = 0;
    if (m_halt) begin
    end else if (m_dw) begin
      if (ddone) m_dw = 0;
    end else if (m_iw) begin
      if (ds) begin m_iw = 0; m_dw = 1; end
      else if (idone) m_iw = 0;
    end else begin
      if (hr && !ds) m_halt = 1;
      else if (ds) m_dw = 1;
      else if (is) m_iw = 1;
    end
  endtask

  task automatic model_reset();
    m_dw = 0; m_iw = 0; m_halt = 0; m_rp = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  initial begin
    vecs[0]  = {7'b0000000, 8'b11111000, 16'd0};
    vecs[1]  = {7'b1000000, 8'b00000000, 16'd0};
    vecs[2]  = {7'b1000000, 8'b00000000, 16'd1};
    vecs[3]  = {7'b1000000, 8'b00000000, 16'd2};
    vecs[4]  = {7'b1100000, 8'b00000000, 16'd3};
    vecs[5]  = {7'b0000000, 8'b11111000, 16'd4};
    vecs[6]  = {7'b0000100, 8'b00111100, 16'd4};
    vecs[7]  = {7'b0000110, 8'b11111110, 16'd5};
    vecs[8]  = {7'b0010010, 8'b00111100, 16'd5};
    vecs[9]  = {7'b0010000, 8'b00111100, 16'd6};
    vecs[10] = {7'b0011000, 8'b00111100, 16'd7};
    vecs[11] = {7'b0000000, 8'b11111110, 16'd8};
    vecs[12] = {7'b0000000, 8'b11111000, 16'd8};
    vecs[13] = {7'b0010000, 8'b00111100, 16'd8};
    vecs[14] = {7'b1010000, 8'b00000000, 16'd9};
    vecs[15] = {7'b1110000, 8'b00000000, 16'd10};
    vecs[16] = {7'b0010000, 8'b00111100, 16'd11};
    vecs[17] = {7'b0011000, 8'b00111100, 16'd12};
    vecs[18] = {7'b0000001, 8'b11111000, 16'd13};
    vecs[19] = {7'b0000000, 8'b00000001, 16'd13};
    vecs[20] = {7'b0000100, 8'b00000001, 16'd13};
    vecs[21] = {7'b1010000, 8'b00000001, 16'd13};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i].in);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].ex, int'(vecs[i].cnt));
      @(posedge clk); #1;
    end

    // Async reset asserted in the middle of a DWAIT cycle
    do_reset();
    set_in(7'b1000000);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_mid_dwait", 8'h00, 0);
    @(posedge clk); #1;
    set_in(7'b0000000);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_run", 8'b11111000, 0);
    @(posedge clk); #1;

    // Saturation: 20 load-use stalls
    do_reset();
    set_in(7'b0000100);
    repeat (20) begin @(posedge clk); #1; end
    set_in(7'b0000000);
    @(negedge clk);
    check("saturate", 8'b11111000, 20);
    @(posedge clk); #1;

    // Randomized run against the model
    do_reset();
    model_reset();
    begin
      int halt_cycles;
      halt_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
        logic [6:0] v;
        logic [7:0] ex;
        bit fs, rd;
        v = {($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 149) == 0)};
        set_in(v);
        if (halt_cycles > 8 || $urandom_range(0, 299) == 0) begin
          rst = 1'b1;
          @(negedge clk);
          check("rand_rst", 8'h00, 0);
          model_reset();
          halt_cycles = 0;
          @(posedge clk); #1;
          rst = 1'b0;
        end else begin
          ex = model_out(v, fs, rd);
          @(negedge clk);
          check($sformatf("rand%0d", n), ex, m_cnt);
          model_step(v, ex, fs, rd);
          if (m_halt) halt_cycles++;
          @(posedge clk); #1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
